// File: rtl/brick_pkg.sv
// Shared types and level pattern definitions for the breakout brick-field manager.
package brick_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    localparam int unsigned HP_W_DEF = 2;
    localparam int unsigned ROW_W    = 8;

    // Raw pattern value; callers clamp to their own HP_MAX, so L2+ returns all ones.
    function automatic int unsigned level_pattern(input int unsigned lvl,
                                                  input int unsigned idx,
                                                  input int unsigned rows);
        int unsigned row;
        row = idx / ROW_W;
        case (lvl)
            0:       return (row < rows / 2) ? 32'd1 : 32'd0;
            1:       return (row % 2 == 1) ? 32'd2 : 32'd1;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/brick_level_rom.sv
// Combinational level/index to hit-point lookup, clamped to the configured HP range.
module brick_level_rom
    import brick_pkg::*;
#(
    parameter int unsigned NUM_BRICKS = 64,
    parameter int unsigned HP_W       = HP_W_DEF,
    parameter int unsigned NUM_LEVELS = 3,
    parameter int unsigned LVL_W      = 3
) (
    input  logic [LVL_W-1:0]              level,
    input  logic [$clog2(NUM_BRICKS)-1:0] idx,
    output logic [HP_W-1:0]               hp
);

    localparam int unsigned HP_MAX = (1 << HP_W) - 1;

    int unsigned lvl_eff;
    int unsigned raw;

    always_comb begin
        lvl_eff = (32'(level) >= NUM_LEVELS) ? NUM_LEVELS - 1 : 32'(level);
        raw     = level_pattern(lvl_eff, 32'(idx), NUM_BRICKS / ROW_W);
        hp      = (raw > HP_MAX) ? HP_W'(HP_MAX) : HP_W'(raw);
    end

endmodule

// File: rtl/brick_map_ctrl.sv
// Brick-field manager: loads a level pattern one brick per cycle, then services hits.
// Optional feature: define BRICK_MAP_SCORE_EN to add the saturating score output.
module brick_map_ctrl
    import brick_pkg::*;
#(
    parameter int unsigned NUM_BRICKS = 64,
    parameter int unsigned HP_W       = 2,
    parameter int unsigned NUM_LEVELS = 3,
    parameter int unsigned LVL_W      = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_req,
    input  logic [LVL_W-1:0]                  level,
    output logic                              load_busy,
    input  logic                              hit_valid,
    input  logic [$clog2(NUM_BRICKS)-1:0]     hit_idx,
    output logic                              hit_ready,
    output logic [NUM_BRICKS*HP_W-1:0]        brick_hp,
    output logic [$clog2(NUM_BRICKS+1)-1:0]   bricks_left,
    output logic                              hit_destroyed,
    output logic                              level_clear
`ifdef BRICK_MAP_SCORE_EN
    ,
    output logic [15:0]                       score
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_BRICKS);
    localparam int unsigned CNT_W = $clog2(NUM_BRICKS + 1);

    state_t           state_q, state_d;
    logic [LVL_W-1:0] level_q;
    logic [IDX_W:0]   load_cnt;
    logic [IDX_W-1:0] wr_idx;
    logic [HP_W-1:0]  rom_hp;
    logic [HP_W-1:0]  cur_hp;
    logic             load_done;
    logic             hit_acc, hit_dec, hit_kill, last_kill;

    brick_level_rom #(
        .NUM_BRICKS (NUM_BRICKS),
        .HP_W       (HP_W),
        .NUM_LEVELS (NUM_LEVELS),
        .LVL_W      (LVL_W)
    ) u_rom (
        .level (level_q),
        .idx   (wr_idx),
        .hp    (rom_hp)
    );

    // load_cnt 0 is the clear cycle; count k writes brick k-1.
    assign wr_idx    = IDX_W'(load_cnt - 1'b1);
    assign load_done = (state_q == LOAD) && (load_cnt == (IDX_W + 1)'(NUM_BRICKS));
    assign load_busy = (state_q == LOAD);
    assign hit_ready = (state_q == RUN) && !load_req;
    assign hit_acc   = hit_valid && hit_ready;
    assign cur_hp    = brick_hp[hit_idx*HP_W +: HP_W];
    assign hit_dec   = hit_acc && (cur_hp != '0);
    assign hit_kill  = hit_dec && (cur_hp == HP_W'(1));
    assign last_kill = hit_kill && (bricks_left == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_req) state_d = LOAD;
            LOAD:    if (load_done) state_d = RUN;
            RUN: begin
                if (load_req)       state_d = LOAD;
                else if (last_kill) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BRICK_MAP_SCORE_EN
    logic [16:0] score_sum;
    assign score_sum = {1'b0, score} + (hit_kill ? 17'd5 : 17'd1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q       <= '0;
            load_cnt      <= '0;
            brick_hp      <= '0;
            bricks_left   <= '0;
            hit_destroyed <= 1'b0;
            level_clear   <= 1'b0;
`ifdef BRICK_MAP_SCORE_EN
            score         <= '0;
`endif
        end else begin
            hit_destroyed <= 1'b0;
            level_clear   <= 1'b0;
            if (state_q != LOAD && load_req) begin
                level_q  <= level;
                load_cnt <= '0;
            end
            case (state_q)
                LOAD: begin
                    load_cnt <= load_cnt + 1'b1;
                    if (load_cnt == '0) begin
                        brick_hp    <= '0;
                        bricks_left <= '0;
`ifdef BRICK_MAP_SCORE_EN
                        score       <= '0;
`endif
                    end else begin
                        brick_hp[wr_idx*HP_W +: HP_W] <= rom_hp;
                        if (rom_hp != '0) bricks_left <= bricks_left + 1'b1;
                    end
                end
                RUN: begin
                    if (hit_dec) begin
                        brick_hp[hit_idx*HP_W +: HP_W] <= cur_hp - 1'b1;
`ifdef BRICK_MAP_SCORE_EN
                        score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                    end
                    if (hit_kill) begin
                        bricks_left   <= bricks_left - 1'b1;
                        hit_destroyed <= 1'b1;
                        level_clear   <= last_kill;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
